// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared types and constants for the direct-mapped data cache
package data_cache_pkg;
   localparam int LINE_W        = 256;
   localparam int OFFSET_W      = 5;
   localparam int SET_BITS_DFLT = 3;
   typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_t;
   typedef logic [OFFSET_W-1:0]      offset_t;
   typedef logic [SET_BITS_DFLT-1:0] index_t;
   typedef logic [26-SET_BITS_DFLT:0] tag_t;
   typedef struct packed {
      tag_t    tag;
      index_t  index;
      offset_t offset;
   } addr_t;
endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: CPU-side and memory-side buses of the data cache
interface data_cache_if;
   import data_cache_pkg::*;
   logic [31:0]       mem_address;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_byte_enable;
   logic              data_read;
   logic              data_write;
   logic [31:0]       mem_rdata;
   logic              mem_resp;
   logic [31:0]       pmem_address;
   logic [LINE_W-1:0] pmem_rdata;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_read;
   logic              pmem_write;
   logic              pmem_resp;
   modport master (
      output mem_address, mem_wdata, mem_byte_enable, data_read, data_write, pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
   );
   modport slave (
      input  mem_address, mem_wdata, mem_byte_enable, data_read, data_write, pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
   );
endinterface

// File: rtl/data_cache_array.sv
// dcache_array: per-set line/tag/valid/dirty storage with byte writes and async read
module dcache_array
   import data_cache_pkg::*;
#(
   parameter int SET_BITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SET_BITS-1:0]   i_index,
   input  logic [LINE_W/8-1:0]   i_byte_we,
   input  logic [LINE_W-1:0]     i_wdata,
   input  logic                  i_fill,
   input  logic [26-SET_BITS:0]  i_tag,
   input  logic                  i_mark_dirty,
   output logic [LINE_W-1:0]     o_line,
   output logic [26-SET_BITS:0]  o_tag,
   output logic                  o_valid,
   output logic                  o_dirty
);
   localparam int SETS = 1 << SET_BITS;
   logic [LINE_W-1:0]    r_data [SETS];
   logic [26-SET_BITS:0] r_tag  [SETS];
   logic [SETS-1:0]      r_valid;
   logic [SETS-1:0]      r_dirty;
   assign o_line  = r_data[i_index];
   assign o_tag   = r_tag[i_index];
   assign o_valid = r_valid[i_index];
   assign o_dirty = r_dirty[i_index];
   // status bits: cleared by reset, a fill makes the set valid and clean, a store dirties it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill) begin
         r_valid[i_index] <= 1'b1;
         r_dirty[i_index] <= 1'b0;
      end else if (i_mark_dirty) begin
         r_dirty[i_index] <= 1'b1;
      end
   end
   // data and tag storage carry no reset; valid gates their use
   always_ff @(posedge clk) begin
      for (int b = 0; b < LINE_W/8; b++)
         if (i_byte_we[b]) r_data[i_index][8*b +: 8] <= i_wdata[8*b +: 8];
      if (i_fill) r_tag[i_index] <= i_tag;
   end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache with a CHECK/WRITEBACK/FILL controller
module data_cache
   import data_cache_pkg::*;
#(
   parameter int SET_BITS = 3
) (
   input  logic       clk,
   input  logic       rst,
   data_cache_if.slave io_bus
);
   localparam int TAG_W = 27 - SET_BITS;
   state_t              r_state;
   state_t              w_next;
   logic [TAG_W-1:0]    w_tag;
   logic [TAG_W-1:0]    w_line_tag;
   logic [SET_BITS-1:0] w_index;
   logic [2:0]          w_word;
   logic                w_req;
   logic                w_hit;
   logic                w_valid;
   logic                w_dirty;
   logic                w_wr_hit;
   logic                w_fill_done;
   logic [LINE_W-1:0]   w_line;
   logic [LINE_W-1:0]   w_wdata;
   logic [LINE_W/8-1:0] w_byte_we;
   logic                w_unused_addr;
   assign w_tag         = io_bus.mem_address[31 -: TAG_W];
   assign w_index       = io_bus.mem_address[OFFSET_W +: SET_BITS];
   assign w_word        = io_bus.mem_address[4:2];
   assign w_unused_addr = ^io_bus.mem_address[1:0];
   assign w_req         = io_bus.data_read | io_bus.data_write;
   assign w_hit         = w_valid && (w_line_tag == w_tag);
   assign w_wr_hit      = (r_state == CHECK) && w_hit && io_bus.data_write && !rst;
   assign w_fill_done   = (r_state == FILL) && io_bus.pmem_resp && !rst;
   assign w_byte_we     = w_fill_done ? '1
                        : w_wr_hit ? ((LINE_W/8)'(io_bus.mem_byte_enable) << {w_word, 2'b00}) : '0;
   assign w_wdata       = (r_state == FILL) ? io_bus.pmem_rdata : {8{io_bus.mem_wdata}};
   dcache_array #(.SET_BITS(SET_BITS)) u_array (
      .clk          (clk),
      .rst          (rst),
      .i_index      (w_index),
      .i_byte_we    (w_byte_we),
      .i_wdata      (w_wdata),
      .i_fill       (w_fill_done),
      .i_tag        (w_tag),
      .i_mark_dirty (w_wr_hit && (|io_bus.mem_byte_enable)),
      .o_line       (w_line),
      .o_tag        (w_line_tag),
      .o_valid      (w_valid),
      .o_dirty      (w_dirty)
   );
   // state register; reset abandons any memory transaction in flight
   always_ff @(posedge clk) begin
      r_state <= rst ? CHECK : w_next;
   end
   // next state: misses evict through WRITEBACK only when the victim is dirty
   always_comb begin
      w_next = (r_state == CHECK) ? ((w_req && !w_hit) ? ((w_valid && w_dirty) ? WRITEBACK : FILL) : CHECK)
             : (r_state == WRITEBACK) ? (io_bus.pmem_resp ? FILL : WRITEBACK)
             : (io_bus.pmem_resp ? CHECK : FILL);
   end
   // outputs: hits answer combinationally, memory requests follow the state
   always_comb begin
      io_bus.mem_rdata    = w_line[{w_word, 5'b0} +: 32];
      io_bus.mem_resp     = (r_state == CHECK) && w_req && w_hit;
      io_bus.pmem_read    = (r_state == FILL);
      io_bus.pmem_write   = (r_state == WRITEBACK);
      io_bus.pmem_address = (r_state == WRITEBACK) ? {w_line_tag, w_index, offset_t'(0)}
                          : (r_state == FILL) ? {w_tag, w_index, offset_t'(0)} : '0;
      io_bus.pmem_wdata   = (r_state == WRITEBACK) ? w_line : '0;
   end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: scoreboard bench for data_cache with a behavioural backing memory
module tb_data_cache;
   import data_cache_pkg::*;
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [255:0] data;
   } txn_t;
   logic clk = 0;
   logic rst = 1;
   always #5 clk = ~clk;
   data_cache_if bus ();
   data_cache dut (.clk(clk), .rst(rst), .io_bus(bus));
   int n_chk = 0;
   int n_fail = 0;
   int pm_cnt = 0;
   bit mon_en = 0;
   txn_t exp_q[$];
   logic [31:0] rd_q[$];
   logic [255:0] shadow[int unsigned];
   logic [255:0] mem[int unsigned];
   bit tv[8];
   bit td[8];
   logic [23:0] tt[8];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] init_line(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = la * 32'h9E3779B1 + 32'(i) * 32'h01010101 + 32'h5A5A0000;
      return l;
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] la);
      return mem.exists(la) ? mem[la] : init_line(la);
   endfunction

   function automatic logic [255:0] cpu_line(input logic [31:0] la);
      return shadow.exists(la) ? shadow[la] : mem_line(la);
   endfunction

   // backing memory: answers each request after three cycles and checks it against the scoreboard
   initial begin
      txn_t e;
      bus.pmem_resp  = 0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.pmem_resp = 0;
         if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
            pm_cnt++;
            if (pm_cnt == 3) begin
               pm_cnt = 0;
               chk("pm_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("pm_kind", bus.pmem_write, e.wr);
                  chk("pm_addr", bus.pmem_address, e.addr);
                  if (e.wr) chk("pm_wdata", bus.pmem_wdata, e.data);
               end
               if (bus.pmem_write === 1'b1) mem[bus.pmem_address] = bus.pmem_wdata;
               else bus.pmem_rdata = mem_line(bus.pmem_address);
               bus.pmem_resp = 1;
            end
         end else begin
            pm_cnt = 0;
         end
      end
   end

   // protocol monitor
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("rw_excl", bus.pmem_read & bus.pmem_write, 0);
         chk("resp_busy", bus.mem_resp & (bus.pmem_read | bus.pmem_write), 0);
      end
   end

   task automatic access(input bit we, input bit rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] la;
      logic [2:0] idx;
      logic [2:0] w;
      logic [23:0] tg;
      logic [255:0] l;
      int lat;
      int n;
      bit got;
      la  = {a[31:5], 5'b0};
      idx = a[7:5];
      w   = a[4:2];
      tg  = a[31:8];
      lat = 1;
      if (!(tv[idx] && tt[idx] == tg)) begin
         if (tv[idx] && td[idx]) begin
            exp_q.push_back('{1'b1, {tt[idx], idx, 5'b0}, cpu_line({tt[idx], idx, 5'b0})});
            lat += 3;
         end
         exp_q.push_back('{1'b0, la, '0});
         lat += 4;
         tv[idx] = 1;
         tt[idx] = tg;
         td[idx] = 0;
      end
      if (we) begin
         l = cpu_line(la);
         for (int b = 0; b < 4; b++) if (be[b]) l[32*w + 8*b +: 8] = wd[8*b +: 8];
         shadow[la] = l;
         if (be != 0) td[idx] = 1;
      end else begin
         l = cpu_line(la);
         rd_q.push_back(l[32*w +: 32]);
      end
      @(posedge clk);
      #1;
      bus.mem_address     = a;
      bus.mem_wdata       = wd;
      bus.mem_byte_enable = be;
      bus.data_read       = rd;
      bus.data_write      = we;
      n = 0;
      got = 0;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.mem_resp === 1'b1) got = 1;
      end
      if (!we) chk("rdata", bus.mem_rdata, rd_q.pop_front());
      chk("latency", n, lat);
      @(posedge clk);
      #1;
      bus.data_read  = 0;
      bus.data_write = 0;
   endtask

   initial begin
      logic [255:0] l;
      bus.mem_address     = 0;
      bus.mem_wdata       = 0;
      bus.mem_byte_enable = 0;
      bus.data_read       = 0;
      bus.data_write      = 0;
      l = init_line(32'h40);
      l[31:0] = 32'hDEADBEEF;
      mem[32'h40] = l;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_resp", bus.mem_resp, 0);
      chk("rst_pread", bus.pmem_read, 0);
      chk("rst_pwrite", bus.pmem_write, 0);
      chk("rst_paddr", bus.pmem_address, 0);
      mon_en = 1;
      access(0, 1, 32'h40, 0, 0);
      access(1, 0, 32'h44, 32'h0000AB00, 4'b0010);
      access(0, 1, 32'h44, 0, 0);
      access(0, 1, 32'h140, 0, 0);
      access(0, 1, 32'h240, 0, 0);
      access(1, 0, 32'h244, 32'hFFFFFFFF, 4'b0000);
      access(0, 1, 32'h244, 0, 0);
      access(0, 1, 32'h40, 0, 0);
      access(1, 1, 32'h5C, 32'h12345678, 4'b1111);
      access(0, 1, 32'h5C, 0, 0);
      access(1, 0, 32'h6C, 32'hCAFEF00D, 4'b1001);
      access(0, 1, 32'h16C, 0, 0);
      @(posedge clk);
      #1;
      bus.mem_address = 32'h80;
      bus.data_read   = 1;
      @(negedge clk);
      @(negedge clk);
      chk("mf_pread", bus.pmem_read, 1);
      rst = 1;
      bus.data_read = 0;
      @(negedge clk);
      chk("mf_pread_drop", bus.pmem_read, 0);
      chk("mf_resp", bus.mem_resp, 0);
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         tv[i] = 0;
         td[i] = 0;
      end
      shadow.delete();
      access(0, 1, 32'h80, 0, 0);
      for (int i = 0; i < 30; i++) begin
         logic [31:0] a;
         bit we;
         a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
         we = 1'($urandom_range(0, 1));
         access(we, we ? 1'($urandom_range(0, 1)) : 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
      end
      chk("exp_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter SET_BITS, default 3, log2 of set count (8 sets); tag width = 27 - SET_BITS.
REQ-002 Ports: clk input 1 system clock; rst input 1 reset, synchronous, active-high; one clock domain.
REQ-003 mem_address input 32: CPU word-aligned byte address, bits [1:0] ignored.
REQ-004 mem_wdata input 32: CPU store data, already lane-aligned.
REQ-005 mem_byte_enable input 4: store byte lanes; bit i enables byte i.
REQ-006 data_read input 1: CPU load request.
REQ-007 data_write input 1: CPU store request.
REQ-008 mem_rdata output 32: load data word.
REQ-009 mem_resp output 1: request complete, one-cycle pulse.
REQ-010 pmem_address output 32: line address, bits [4:0] = 0.
REQ-011 pmem_rdata input 256: fill line from memory.
REQ-012 pmem_wdata output 256: victim line to memory.
REQ-013 pmem_read output 1: line fill request.
REQ-014 pmem_write output 1: line writeback request.
REQ-015 pmem_resp input 1: memory transaction complete, one-cycle pulse.

Function
REQ-016 Direct-mapped, write-back, write-allocate; 32-byte lines; offset [4:0], word [4:2], index [4+SET_BITS:5], tag [31:5+SET_BITS].
REQ-017 CPU holds address, data, enables and request stable from assertion until the cycle mem_resp = 1.
REQ-018 FSM states: CHECK, WRITEBACK, FILL; reset state CHECK.
REQ-019 CHECK, no request: all outputs 0 except mem_rdata (don't-care); state holds.
REQ-020 CHECK, request, valid and tag match (hit): mem_resp = 1 same cycle; zero added latency.
REQ-021 Read hit: mem_rdata = selected word of indexed line, combinational in that cycle.
REQ-022 Write hit: enabled bytes of selected word updated at that clock edge; dirty set if mem_byte_enable != 0; enable 0000 still responds, no data or dirty change.
REQ-023 data_read and data_write both high: treated as write.
REQ-024 CHECK miss, victim invalid or clean: next state FILL. Miss, victim valid and dirty: next state WRITEBACK.
REQ-025 WRITEBACK: pmem_write = 1, pmem_address = {victim tag, index, 5'b0}, pmem_wdata = victim line, held until pmem_resp; then next state FILL.
REQ-026 FILL: pmem_read = 1, pmem_address = {request tag, index, 5'b0}, held until pmem_resp. On pmem_resp: line written with pmem_rdata, tag written, valid set, dirty cleared; next state CHECK.
REQ-027 After FILL, access re-evaluated in CHECK as a hit; miss latency = memory cycles + 1.
REQ-028 mem_resp never asserted in WRITEBACK or FILL; pmem_read and pmem_write never both 1.
REQ-029 pmem_resp outside WRITEBACK/FILL ignored.

Reset
REQ-030 rst clears all valid and dirty bits; state CHECK; mem_resp, pmem_read, pmem_write = 0 the cycle after rst is sampled.
REQ-031 rst during WRITEBACK or FILL abandons the transaction; no array update; pmem request drops next cycle.
REQ-032 Data and tag arrays are not reset.

Structure
REQ-033 Shared package holds the state enum (CHECK, WRITEBACK, FILL), line width 256, offset width 5, and the tag/index/offset field types.
REQ-034 One sub-module, dcache_array: per-set line, tag, valid, dirty storage; per-byte write enable for 32-byte lines; asynchronous read.
REQ-035 FSM and hit logic live in data_cache; target 200-350 RTL lines.

Verification
REQ-036 After reset, read 0x0000_0040 -> pmem_read, pmem_address 0x0000_0040; pmem_resp with word 0 = 0xDEADBEEF -> next cycle mem_resp, mem_rdata 0xDEADBEEF.
REQ-037 Write 0x0000_0044, data 0x0000AB00, enable 0010 on resident line -> mem_resp same cycle; read 0x44 returns byte 1 = 0xAB, other bytes unchanged.
REQ-038 Dirty line at 0x40 (index 2), then read 0x0000_0140 -> pmem_write at 0x40 with modified line, then pmem_read at 0x140, then mem_resp.
REQ-039 Read miss on clean line, index 2 -> no pmem_write; pmem_read only.
REQ-040 rst asserted mid-FILL -> pmem_read 0 next cycle; later read to same address misses again.
REQ-041 Write with enable 0000 on hit -> mem_resp; later eviction issues no writeback.
